speed_sched: RTL and testbench

Run/pause and speed-level controller for the LED step counter. It takes single-cycle key pulses (faster, slower, pause/resume) and keeps a 2-bit speed level. From that level it derives the prescaler period (BASE_TICKS >> level) and advances a 6-bit step index once per period while running. It sits between the key debouncers and the LED pattern decoder, replacing the fixed 250 ms stepper with a sequenced, reconfigurable one.

---
 rtl/speed_sched_if.sv | 22 ++
 rtl/speed_sched.sv | 157 +++++++++++++++
 tb/tb_speed_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/speed_sched_if.sv
// speed_sched_if: key pulses in, step/level/run status out.
// The master side (key debouncers or a bench) drives the keys; the
// slave side (speed_sched) drives the step counter status.
interface speed_sched_if;
  logic       key_up;
  logic       key_down;
  logic       key_pause;
  logic [5:0] step;
  logic       tick;
  logic [1:0] level;
  logic       running;

  modport master (
    output key_up, key_down, key_pause,
    input  step, tick, level, running
  );

  modport slave (
    input  key_up, key_down, key_pause,
    output step, tick, level, running
  );
endinterface

// File: rtl/speed_sched.sv
// speed_sched: run/pause and speed-level controller for the LED stepper.
// A 2-bit speed level selects the prescaler period BASE_TICKS >> level;
// while running, the 6-bit step index advances once per period and tick
// pulses on the cycle the new step value appears.
// Optional feature macro: SPEED_SCHED_BOUNCE_EN (step ping-pongs 0..63..0
// instead of wrapping 63 -> 0).
module speed_sched #(
  parameter int BASE_TICKS = 12_500_000,
  parameter int PRE_W      = 26
) (
  input  logic         clk,
  input  logic         rst,
  speed_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] BASE_P = PRE_W'(BASE_TICKS);

  state_t           state_r, state_nxt_s;
  logic [PRE_W-1:0] pre_r, pre_nxt_s;
  logic [5:0]       step_r, step_nxt_s, step_adv_s;
  logic             tick_r, tick_nxt_s;
  logic [1:0]       level_r, level_nxt_s, level_new_s;
  logic             running_r;
  logic [PRE_W-1:0] period_s;
  logic             tc_s;
  logic             up_ok_s, down_ok_s, lvl_chg_s;
`ifdef SPEED_SCHED_BOUNCE_EN
  logic             dir_down_r, dir_nxt_s, dir_adv_s;
`endif

  // Period for the current level and terminal-count detect (only meaningful in RUN).
  assign period_s = BASE_P >> level_r;
  assign tc_s     = (state_r == ST_RUN) && (pre_r == (period_s - PRE_W'(1)));

  // Level keys: pause has priority, up+down together cancel, saturated presses vanish.
  assign up_ok_s     = bus.key_up && !bus.key_down && (level_r != 2'd3);
  assign down_ok_s   = bus.key_down && !bus.key_up && (level_r != 2'd0);
  assign lvl_chg_s   = !bus.key_pause && (up_ok_s || down_ok_s);
  assign level_new_s = up_ok_s ? (level_r + 2'd1) : (level_r - 2'd1);

`ifdef SPEED_SCHED_BOUNCE_EN
  // Next step value in ping-pong mode; direction flips on reaching 63 or 0.
  always_comb begin
    step_adv_s = step_r;
    dir_adv_s  = dir_down_r;
    if (dir_down_r) begin
      step_adv_s = step_r - 6'd1;
      dir_adv_s  = (step_adv_s != 6'd0);
    end else begin
      step_adv_s = step_r + 6'd1;
      dir_adv_s  = (step_adv_s == 6'd63);
    end
  end
`else
  // Next step value in wrapping mode (6-bit modulo 64).
  assign step_adv_s = step_r + 6'd1;
`endif

  // Next-state and next-output logic for the PAUSE/RUN/RELOAD sequencer.
  always_comb begin
    state_nxt_s = state_r;
    pre_nxt_s   = pre_r;
    step_nxt_s  = step_r;
    tick_nxt_s  = 1'b0;
    level_nxt_s = level_r;
`ifdef SPEED_SCHED_BOUNCE_EN
    dir_nxt_s   = dir_down_r;
`endif
    case (state_r)
      ST_PAUSE: begin
        if (bus.key_pause) begin
          state_nxt_s = ST_RUN;
          pre_nxt_s   = '0;
        end else if (lvl_chg_s) begin
          level_nxt_s = level_new_s;
          pre_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_RUN: begin
        // The terminal count is honoured even when a key arrives on the same edge.
        if (tc_s) begin
          pre_nxt_s  = '0;
          step_nxt_s = step_adv_s;
          tick_nxt_s = 1'b1;
`ifdef SPEED_SCHED_BOUNCE_EN
          dir_nxt_s  = dir_adv_s;
`endif
        end else begin
          pre_nxt_s = pre_r + PRE_W'(1);
        end
        if (bus.key_pause) begin
          state_nxt_s = ST_PAUSE;
        end else if (lvl_chg_s) begin
          state_nxt_s = ST_RELOAD;
          level_nxt_s = level_new_s;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RELOAD: begin
        // One idle cycle so the prescaler restarts cleanly on the new period.
        pre_nxt_s = '0;
        if (bus.key_pause) begin
          state_nxt_s = ST_PAUSE;
        end else if (lvl_chg_s) begin
          state_nxt_s = ST_RELOAD;
          level_nxt_s = level_new_s;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_PAUSE;
        pre_nxt_s   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_PAUSE;
      pre_r      <= '0;
      step_r     <= 6'd0;
      tick_r     <= 1'b0;
      level_r    <= 2'd0;
      running_r  <= 1'b0;
`ifdef SPEED_SCHED_BOUNCE_EN
      dir_down_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      pre_r      <= pre_nxt_s;
      step_r     <= step_nxt_s;
      tick_r     <= tick_nxt_s;
      level_r    <= level_nxt_s;
      running_r  <= (state_nxt_s != ST_PAUSE);
`ifdef SPEED_SCHED_BOUNCE_EN
      dir_down_r <= dir_nxt_s;
`endif
    end
  end

  assign bus.step    = step_r;
  assign bus.tick    = tick_r;
  assign bus.level   = level_r;
  assign bus.running = running_r;

endmodule

// File: tb/tb_speed_sched.sv
// tb_speed_sched: scoreboard bench for speed_sched with BASE_TICKS = 8.
// A tick-countdown reference model predicts outputs every edge; a monitor
// compares them on the falling edge. Directed phases follow the test plan,
// followed by a randomized key/reset phase.
module tb_speed_sched;
  localparam int BT = 8;

  logic clk = 1'b0;
  logic rst;

  speed_sched_if sif();

  speed_sched #(.BASE_TICKS(BT), .PRE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] step;
    logic       tick;
    logic [1:0] level;
    logic       running;
  } obs_t;

  obs_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int per(int lv);
    return BT >> lv;
  endfunction

  // Step value after idx ticks since reset.
  function automatic int step_of(int idx);
    int k;
`ifdef SPEED_SCHED_BOUNCE_EN
    k = idx % 126;
    return (k <= 63) ? k : 126 - k;
`else
    k = idx % 64;
    return k;
`endif
  endfunction

  // Reference model: running flag, level, edges remaining to next tick, tick count.
  int   m_run = 0, m_level = 0, m_remain = 0, m_idx = 0, m_nl;
  logic m_t;
  obs_t m_e;
  always @(posedge clk) begin
    m_t = 1'b0;
    if (rst) begin
      m_run = 0; m_level = 0; m_remain = 0; m_idx = 0;
    end else begin
      if (m_run != 0) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          m_t = 1'b1;
          m_idx = m_idx + 1;
          m_remain = per(m_level);
        end
      end
      if (sif.key_pause) begin
        if (m_run != 0) m_run = 0;
        else begin
          m_run = 1;
          m_remain = per(m_level);
        end
      end else if (sif.key_up != sif.key_down) begin
        m_nl = sif.key_up ? m_level + 1 : m_level - 1;
        if (m_nl >= 0 && m_nl <= 3) begin
          m_level = m_nl;
          if (m_run != 0) m_remain = per(m_nl) + 1;
        end
      end
    end
    m_e.step    = 6'(step_of(m_idx));
    m_e.tick    = m_t;
    m_e.level   = 2'(m_level);
    m_e.running = (m_run != 0);
    exp_q.push_back(m_e);
  end

  // Monitor: compare every observed cycle against the queued prediction.
  obs_t mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {sif.step, sif.tick, sif.level, sif.running};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t actual step=%0d tick=%0b level=%0d running=%0b required step=%0d tick=%0b level=%0d running=%0b",
                 $time, mon_a.step, mon_a.tick, mon_a.level, mon_a.running,
                 mon_e.step, mon_e.tick, mon_e.level, mon_e.running);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  int cyc = 0, last_tick = -1, tick_cnt = 0, gmin = 1000, gmax = 0;

  task automatic stats_clear();
    tick_cnt = 0; gmin = 1000; gmax = 0;
  endtask

  // Advance n falling edges, tracking tick count and inter-tick gaps.
  task automatic run(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (sif.tick === 1'b1) begin
        if (last_tick >= 0) begin
          g = cyc - last_tick;
          if (g < gmin) gmin = g;
          if (g > gmax) gmax = g;
        end
        last_tick = cyc;
        tick_cnt++;
      end
    end
  endtask

  task automatic press(input logic u, input logic d, input logic p);
    sif.key_up = u; sif.key_down = d; sif.key_pause = p;
    run(1);
    sif.key_up = 1'b0; sif.key_down = 1'b0; sif.key_pause = 1'b0;
  endtask

  int first_tick, prev_cnt, r;

  initial begin
    rst = 1'b1;
    sif.key_up = 1'b0; sif.key_down = 1'b0; sif.key_pause = 1'b0;
    run(3);
    rst = 1'b0;

    // Reset state and idle.
    chk("reset_step", sif.step, 0);
    chk("reset_level", sif.level, 0);
    stats_clear();
    run(20);
    chk("idle_ticks", tick_cnt, 0);
    chk("idle_running", sif.running, 0);
    chk("idle_step", sif.step, 0);
    chk("idle_level", sif.level, 0);

    // Resume and run 40 cycles.
    press(1'b0, 1'b0, 1'b1);
    chk("resume_running", sif.running, 1);
    stats_clear();
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      prev_cnt = tick_cnt;
      run(1);
      if (tick_cnt != prev_cnt && first_tick < 0) first_tick = i;
    end
    chk("first_tick_delay", first_tick, 8);
    chk("run40_gap", gmax, 8);
    chk("run40_step", sif.step, 5);

    // Speed up three times, then a saturated fourth press.
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0, 1'b0);
      chk("up_level", sif.level, k);
      last_tick = -1;
      stats_clear();
      run(19);
      chk("up_gap_min", gmin, 8 >> k);
      chk("up_gap_max", gmax, 8 >> k);
    end
    stats_clear();
    press(1'b1, 1'b0, 1'b0);
    run(19);
    chk("up_sat_level", sif.level, 3);
    chk("up_sat_ticks", tick_cnt, 20);
    chk("up_sat_gap", gmax, 1);

    // Up and down together at level 3.
    stats_clear();
    press(1'b1, 1'b1, 1'b0);
    run(19);
    chk("updown3_level", sif.level, 3);
    chk("updown3_ticks", tick_cnt, 20);

    // Slow down to level 0.
    for (int k = 2; k >= 0; k--) begin
      press(1'b0, 1'b1, 1'b0);
      chk("down_level", sif.level, k);
      run(20);
    end
    run(10);
    stats_clear();
    press(1'b0, 1'b1, 1'b0);
    run(29);
    chk("down_sat_level", sif.level, 0);
    chk("down_sat_gap_min", gmin, 8);
    chk("down_sat_gap_max", gmax, 8);
    stats_clear();
    press(1'b1, 1'b1, 1'b0);
    run(29);
    chk("updown0_level", sif.level, 0);
    chk("updown0_gap_min", gmin, 8);
    chk("updown0_gap_max", gmax, 8);

    // Pause on the terminal-count edge.
    rst = 1'b1; run(1); rst = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    stats_clear();
    for (int i = 0; i < 20 && tick_cnt == 0; i++) run(1);
    chk("pt_first_tick_seen", tick_cnt, 1);
    chk("pt_first_step", sif.step, 1);
    run(7);
    press(1'b0, 1'b0, 1'b1);
    chk("pt_tick", sif.tick, 1);
    chk("pt_running", sif.running, 0);
    chk("pt_step", sif.step, 2);
    stats_clear();
    run(20);
    chk("pt_no_ticks", tick_cnt, 0);
    chk("pt_step_held", sif.step, 2);

    // Randomized keys and occasional resets; checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      rst = (r == 199);
      if (r < 6)       press(1'b0, 1'b0, 1'b1);
      else if (r < 16) press(1'b1, 1'b0, 1'b0);
      else if (r < 26) press(1'b0, 1'b1, 1'b0);
      else if (r < 29) press(1'b1, 1'b1, 1'b0);
      else if (r < 32) press(1'b1, 1'b0, 1'b1);
      else if (r < 35) press(1'b0, 1'b1, 1'b1);
      else             run(1);
    end
    rst = 1'b0;

    // Level 3 for 70 ticks: wrap or bounce.
    rst = 1'b1; run(1); rst = 1'b0;
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    stats_clear();
    for (int i = 0; i < 300 && tick_cnt < 70; i++) begin
      prev_cnt = tick_cnt;
      run(1);
      if (tick_cnt != prev_cnt) begin
        if (tick_cnt == 63) chk("tick63_step", sif.step, 63);
`ifdef SPEED_SCHED_BOUNCE_EN
        if (tick_cnt == 64) chk("tick64_step", sif.step, 62);
        if (tick_cnt == 69) chk("tick69_step", sif.step, 57);
`else
        if (tick_cnt == 64) chk("tick64_step", sif.step, 0);
        if (tick_cnt == 69) chk("tick69_step", sif.step, 5);
`endif
      end
    end
    chk("level3_tick_count", tick_cnt, 70);

    // Reset mid-run overrides a simultaneous key.
    rst = 1'b1;
    sif.key_pause = 1'b1;
    run(1);
    rst = 1'b0;
    sif.key_pause = 1'b0;
    chk("midrst_step", sif.step, 0);
    chk("midrst_level", sif.level, 0);
    chk("midrst_running", sif.running, 0);
    chk("midrst_tick", sif.tick, 0);
    run(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
